// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encoding, default widths and
// small helpers used by the router output stage.
package noc_pkg;

  localparam int FLIT_W  = 37;
  localparam int N_PORTS = 5;

  typedef enum logic [1:0] {
    FT_HEAD      = 2'b00,
    FT_BODY      = 2'b01,
    FT_TAIL      = 2'b10,
    FT_HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } alloc_state_e;

  // Type field lives in the two MSBs of every flit.
  function automatic flit_type_e flit_type(input logic [FLIT_W-1:0] flit);
    return flit_type_e'(flit[FLIT_W-1 -: 2]);
  endfunction

  function automatic logic is_head(input flit_type_e t);
    return (t == FT_HEAD) || (t == FT_HEAD_TAIL);
  endfunction

  function automatic logic is_tail(input flit_type_e t);
    return (t == FT_TAIL) || (t == FT_HEAD_TAIL);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request found scanning
// from ptr upward (mod N). Pointer ownership stays with the caller.
module rr_arbiter #(
  parameter int N = 5,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  int  j;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/output_port_allocator.sv
// Wormhole output-port allocator: round-robin grant on head flits, the
// owner holds the output link until its tail (or a forced release).
module output_port_allocator #(
  parameter int N_IN          = 5,
  parameter int FLIT_W        = 37,
  parameter int MAX_PKT_FLITS = 16
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic [N_IN-1:0]          req_i,
  input  logic [N_IN*FLIT_W-1:0]   flit_i,
  input  logic [N_IN-1:0]          valid_i,
  output logic [N_IN-1:0]          ready_o,
  output logic [FLIT_W-1:0]        out_flit_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [N_IN-1:0]          grant_o,
  output logic                     proto_err_o
);
  import noc_pkg::*;

  localparam int IW    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int CNT_W = $clog2(MAX_PKT_FLITS + 1);

  alloc_state_e     state_q, state_d;
  logic [N_IN-1:0]  grant_q;
  logic [IW-1:0]    owner_q, rr_ptr_q;
  logic [CNT_W-1:0] flit_cnt_q;
  logic             err_q;

  flit_type_e       in_type [N_IN];
  logic [N_IN-1:0]  cand, stray;
  logic [N_IN-1:0]  arb_gnt;
  logic [IW-1:0]    arb_idx;

  logic [FLIT_W-1:0] sel_flit;
  flit_type_e        sel_type;
  logic              locked, xfer, rel_tail, rel_force, head_err, release_pkt, err_d;

  // Heads may compete; body/tail without a lock are strays.
  for (genvar i = 0; i < N_IN; i++) begin : g_in
    assign in_type[i] = flit_type_e'(flit_i[i*FLIT_W + FLIT_W - 2 +: 2]);
    assign cand[i]    = req_i[i] & valid_i[i] & is_head(in_type[i]);
    assign stray[i]   = req_i[i] & valid_i[i] & ~is_head(in_type[i]);
  end

  rr_arbiter #(.N(N_IN)) u_arb (
    .req (cand),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign locked      = (state_q == S_LOCKED);
  assign sel_flit    = flit_i[owner_q*FLIT_W +: FLIT_W];
  assign sel_type    = flit_type_e'(sel_flit[FLIT_W-1 -: 2]);
  assign xfer        = locked & valid_i[owner_q] & out_ready_i;
  assign rel_tail    = xfer & is_tail(sel_type);
  assign rel_force   = xfer & ~is_tail(sel_type) & (flit_cnt_q >= CNT_W'(MAX_PKT_FLITS - 1));
  assign head_err    = xfer & (sel_type == FT_HEAD) & (flit_cnt_q != '0);
  assign release_pkt = rel_tail | rel_force;
  assign err_d       = locked ? (rel_force | head_err) : (~(|cand) & (|stray));

  always_ff @(posedge clk) begin
    if (arst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (|cand)      state_d = S_LOCKED;
      S_LOCKED: if (release_pkt) state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // grant_q is zero whenever idle, so it gates the demux and valid mux.
  always_comb begin
    grant_o     = grant_q;
    ready_o     = grant_q & {N_IN{out_ready_i}};
    out_valid_o = |(grant_q & valid_i);
    out_flit_o  = locked ? sel_flit : '0;
    proto_err_o = err_q;
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      grant_q    <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      flit_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= err_d;
      if (!locked && (|cand)) begin
        grant_q    <= arb_gnt;
        owner_q    <= arb_idx;
        flit_cnt_q <= '0;
      end else begin
        if (xfer && flit_cnt_q != CNT_W'(MAX_PKT_FLITS))
          flit_cnt_q <= flit_cnt_q + 1'b1;
        if (release_pkt) begin
          grant_q  <= '0;
          rr_ptr_q <= (owner_q == IW'(N_IN - 1)) ? '0 : owner_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_output_port_allocator.sv
// Bench for output_port_allocator: a cycle table for reset/single-flit
// arbitration, plus scheduled multi-cycle packet sequences.
module tb_output_port_allocator;
  import noc_pkg::*;

  localparam int N  = 5;
  localparam int FW = 37;

  logic            clk = 1'b0;
  logic            arst;
  logic [N-1:0]    req_i, valid_i, ready_o, grant_o;
  logic [N*FW-1:0] flit_i;
  logic [FW-1:0]   out_flit_o;
  logic            out_valid_o, out_ready_i, proto_err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  output_port_allocator #(.N_IN(N), .FLIT_W(FW), .MAX_PKT_FLITS(16)) dut (
    .clk         (clk),
    .arst        (arst),
    .req_i       (req_i),
    .flit_i      (flit_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .out_flit_o  (out_flit_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .grant_o     (grant_o),
    .proto_err_o (proto_err_o)
  );

  function automatic logic [FW-1:0] mk_flit(input logic [1:0] t, input int src, input int k);
    logic [FW-3:0] pl;
    pl = 35'(32'h5a000 + src * 4096 + k * 16);
    return {t, pl};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [4:0] req, val;
    logic [9:0] typ;
    logic       outr;
    logic [4:0] g, r;
    logic       ov, err;
  } row_t;

  typedef struct {
    logic       rst;
    logic       outr;
    logic [4:0] en;
    int         own;
    logic       err;
  } step_t;

  row_t  tbl[15];
  step_t sq[$];
  int    len[N];
  int    kk[N];

  function automatic logic [1:0] src_type(input int i);
    if (len[i] == 1)          return 2'b11;
    if (kk[i] == 0)           return 2'b00;
    if (kk[i] == len[i] - 1)  return 2'b10;
    return 2'b01;
  endfunction

  task automatic add(input logic rst, input logic outr, input logic [4:0] en,
                     input int own, input logic err);
    step_t s;
    s.rst = rst; s.outr = outr; s.en = en; s.own = own; s.err = err;
    sq.push_back(s);
  endtask

  task automatic reset_dut();
    arst = 1'b1; req_i = '0; valid_i = '0; out_ready_i = 1'b0; flit_i = '0;
    repeat (2) @(posedge clk);
    #1;
    arst = 1'b0;
    for (int i = 0; i < N; i++) begin kk[i] = 0; len[i] = 1; end
  endtask

  task automatic run_table();
    logic [FW-1:0] ef;
    int idx;
    for (int r = 0; r < 15; r++) begin
      arst = tbl[r].rst; req_i = tbl[r].req; valid_i = tbl[r].val; out_ready_i = tbl[r].outr;
      for (int i = 0; i < N; i++) flit_i[i*FW +: FW] = mk_flit(tbl[r].typ[2*i +: 2], i, 0);
      @(negedge clk);
      chk($sformatf("tbl%0d grant", r), 64'(grant_o), 64'(tbl[r].g));
      chk($sformatf("tbl%0d ready", r), 64'(ready_o), 64'(tbl[r].r));
      chk($sformatf("tbl%0d out_valid", r), 64'(out_valid_o), 64'(tbl[r].ov));
      chk($sformatf("tbl%0d proto_err", r), 64'(proto_err_o), 64'(tbl[r].err));
      ef = '0;
      idx = -1;
      for (int i = 0; i < N; i++) if (tbl[r].g[i]) idx = i;
      if (idx >= 0) ef = mk_flit(tbl[r].typ[2*idx +: 2], idx, 0);
      chk($sformatf("tbl%0d out_flit", r), 64'(out_flit_o), 64'(ef));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_sched(input string tag);
    logic [N-1:0] exp_g, exp_r;
    logic         adv;
    for (int s = 0; s < sq.size(); s++) begin
      arst = sq[s].rst; out_ready_i = sq[s].outr;
      for (int i = 0; i < N; i++) begin
        req_i[i]   = sq[s].en[i];
        valid_i[i] = sq[s].en[i];
        flit_i[i*FW +: FW] = mk_flit(src_type(i), i, kk[i]);
      end
      exp_g = '0;
      if (sq[s].own >= 0) exp_g[sq[s].own] = 1'b1;
      exp_r = sq[s].outr ? exp_g : '0;
      @(negedge clk);
      chk($sformatf("%s[%0d] grant", tag, s), 64'(grant_o), 64'(exp_g));
      chk($sformatf("%s[%0d] ready", tag, s), 64'(ready_o), 64'(exp_r));
      chk($sformatf("%s[%0d] proto_err", tag, s), 64'(proto_err_o), 64'(sq[s].err));
      chk($sformatf("%s[%0d] out_valid", tag, s), 64'(out_valid_o), 64'(sq[s].own >= 0));
      if (sq[s].own >= 0)
        chk($sformatf("%s[%0d] out_flit", tag, s), 64'(out_flit_o),
            64'(mk_flit(src_type(sq[s].own), sq[s].own, kk[sq[s].own])));
      adv = (sq[s].own >= 0) && sq[s].outr && !sq[s].rst;
      @(posedge clk);
      #1;
      if (adv) kk[sq[s].own] = (kk[sq[s].own] == len[sq[s].own] - 1) ? 0 : kk[sq[s].own] + 1;
    end
    sq.delete();
  endtask

  initial begin
    int owners[3];
    owners[0] = 0; owners[1] = 1; owners[2] = 4;

    // rst, req, val, types, outr, grant, ready, ovalid, err
    tbl[0]  = '{1'b1, 5'h1f, 5'h1f, 10'h000, 1'b1, 5'h00, 5'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 5'h1f, 5'h1f, 10'h000, 1'b1, 5'h00, 5'h00, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 5'h04, 5'h04, 10'h030, 1'b1, 5'h00, 5'h00, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 5'h04, 5'h04, 10'h030, 1'b1, 5'h04, 5'h04, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 5'h00, 5'h00, 10'h000, 1'b1, 5'h00, 5'h00, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 5'h11, 5'h11, 10'h303, 1'b1, 5'h00, 5'h00, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 5'h11, 5'h11, 10'h303, 1'b1, 5'h10, 5'h10, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 5'h11, 5'h11, 10'h303, 1'b1, 5'h00, 5'h00, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 5'h11, 5'h11, 10'h303, 1'b1, 5'h01, 5'h01, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 5'h00, 5'h00, 10'h000, 1'b1, 5'h00, 5'h00, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 5'h02, 5'h02, 10'h004, 1'b1, 5'h00, 5'h00, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 5'h02, 5'h02, 10'h004, 1'b1, 5'h00, 5'h00, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 5'h02, 5'h02, 10'h008, 1'b1, 5'h00, 5'h00, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 5'h00, 5'h00, 10'h000, 1'b1, 5'h00, 5'h00, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 5'h00, 5'h00, 10'h000, 1'b1, 5'h00, 5'h00, 1'b0, 1'b0};

    reset_dut();
    run_table();

    // Three inputs streaming 3-flit packets back to back.
    reset_dut();
    len[0] = 3; len[1] = 3; len[4] = 3;
    for (int p = 0; p < 6; p++) begin
      add(1'b0, 1'b1, 5'b10011, -1, 1'b0);
      repeat (3) add(1'b0, 1'b1, 5'b10011, owners[p % 3], 1'b0);
    end
    run_sched("stream");

    // Backpressure mid-packet with a competing head waiting.
    reset_dut();
    len[3] = 4; len[0] = 1;
    add(1'b0, 1'b1, 5'b01000, -1, 1'b0);
    add(1'b0, 1'b1, 5'b01000, 3, 1'b0);
    add(1'b0, 1'b1, 5'b01001, 3, 1'b0);
    repeat (5) add(1'b0, 1'b0, 5'b01001, 3, 1'b0);
    add(1'b0, 1'b1, 5'b01001, 3, 1'b0);
    add(1'b0, 1'b1, 5'b01001, 3, 1'b0);
    add(1'b0, 1'b1, 5'b01001, -1, 1'b0);
    add(1'b0, 1'b1, 5'b01001, 0, 1'b0);
    run_sched("bp");

    // Packet without tail: forced release after 16 flits, then stray body.
    reset_dut();
    len[1] = 100; len[2] = 1;
    add(1'b0, 1'b1, 5'b00110, -1, 1'b0);
    repeat (16) add(1'b0, 1'b1, 5'b00110, 1, 1'b0);
    add(1'b0, 1'b1, 5'b00110, -1, 1'b1);
    add(1'b0, 1'b1, 5'b00110, 2, 1'b0);
    add(1'b0, 1'b1, 5'b00010, -1, 1'b0);
    add(1'b0, 1'b1, 5'b00010, -1, 1'b1);
    add(1'b0, 1'b1, 5'b00000, -1, 1'b1);
    add(1'b0, 1'b1, 5'b00000, -1, 1'b0);
    run_sched("force");

    // Reset mid-packet restores the pointer to 0.
    reset_dut();
    len[1] = 1; len[3] = 4; len[0] = 1; len[4] = 1;
    add(1'b0, 1'b1, 5'b00010, -1, 1'b0);
    add(1'b0, 1'b1, 5'b00010, 1, 1'b0);
    add(1'b0, 1'b1, 5'b01000, -1, 1'b0);
    add(1'b0, 1'b1, 5'b01000, 3, 1'b0);
    add(1'b0, 1'b1, 5'b01000, 3, 1'b0);
    add(1'b1, 1'b1, 5'b01000, 3, 1'b0);
    add(1'b0, 1'b1, 5'b10001, -1, 1'b0);
    add(1'b0, 1'b1, 5'b10001, 0, 1'b0);
    run_sched("rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
